// File: rtl/sargantana_icache_ifill_unit.sv
// Instruction-cache refill engine: issues one line fill to L2, assembles the
// response beats, and merges L2 invalidations onto the single fill response.

module sargantana_icache_ifill_slot #(
    parameter int W = 128
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         we_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)   r_q <= '0;
        else if (we_i) r_q <= d_i;
    end

    assign q_o = r_q;
endmodule

module sargantana_icache_ifill_unit #(
    parameter int  PADDR_WIDTH = 40,
    parameter int  LINE_BITS   = 256,
    parameter int  BEAT_BITS   = 128,
    parameter int  N_WAY       = 4,
    localparam int N_BEATS     = LINE_BITS / BEAT_BITS,
    localparam int BEAT_W      = $clog2(N_BEATS),
    localparam int WAY_W       = $clog2(N_WAY)
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   req_valid_i,
    input  logic [PADDR_WIDTH-1:0] req_paddr_i,
    input  logic [WAY_W-1:0]       req_way_i,
    input  logic                   req_kill_i,
    output logic                   l2_req_valid_o,
    input  logic                   l2_req_ready_i,
    output logic [PADDR_WIDTH-1:0] l2_req_paddr_o,
    input  logic                   l2_resp_valid_i,
    input  logic [BEAT_W-1:0]      l2_resp_beat_i,
    input  logic [BEAT_BITS-1:0]   l2_resp_data_i,
    input  logic                   l2_inv_valid_i,
    input  logic [PADDR_WIDTH-1:0] l2_inv_paddr_i,
    output logic                   l2_inv_ready_o,
    output logic                   ifill_valid_o,
    output logic                   ifill_inv_valid_o,
    output logic [PADDR_WIDTH-1:0] ifill_inv_paddr_o,
    output logic [LINE_BITS-1:0]   ifill_data_o,
    output logic [WAY_W-1:0]       ifill_way_o,
    output logic                   busy_o
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEND    = 3'd1,
        S_WAIT    = 3'd2,
        S_DRAIN   = 3'd3,
        S_DELIVER = 3'd4
    } state_e;

    state_e                 r_state, w_state_n;
    logic [BEAT_W-1:0]      r_cnt, w_cnt_n;
    logic                   r_kill, w_kill_n;
    logic [PADDR_WIDTH-1:0] r_paddr;
    logic [WAY_W-1:0]       r_way;
    logic                   r_inv_pending;
    logic [PADDR_WIDTH-1:0] r_inv_paddr;

    logic                   w_accept;
    logic                   w_last;
    logic                   w_inv_acc;
    logic [N_BEATS-1:0][BEAT_BITS-1:0] w_line;

    assign w_accept  = (r_state == S_IDLE) && req_valid_i && !req_kill_i;
    assign w_last    = l2_resp_valid_i && (r_cnt == BEAT_W'(N_BEATS-1));
    assign w_inv_acc = l2_inv_valid_i && !r_inv_pending;

    // Only WAIT captures data; beats consumed in DRAIN never touch the buffer.
    genvar g;
    generate
        for (g = 0; g < N_BEATS; g++) begin : g_slot
            logic w_we;
            assign w_we = (r_state == S_WAIT) && l2_resp_valid_i &&
                          (l2_resp_beat_i == BEAT_W'(g));
            sargantana_icache_ifill_slot #(.W(BEAT_BITS)) u_slot (
                .clk_i  (clk_i),
                .rstn_i (rstn_i),
                .we_i   (w_we),
                .d_i    (l2_resp_data_i),
                .q_o    (w_line[g])
            );
        end
    endgenerate

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_kill_n  = r_kill;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_n = S_SEND;
            end
            S_SEND: begin
                if (req_kill_i) w_kill_n = 1'b1;
                if (l2_req_ready_i)
                    w_state_n = (r_kill || req_kill_i) ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (l2_resp_valid_i) w_cnt_n = r_cnt + 1'b1;
                // A kill alongside the final beat drops the line outright.
                if (w_last) begin
                    w_cnt_n   = '0;
                    w_state_n = req_kill_i ? S_IDLE : S_DELIVER;
                end else if (req_kill_i) begin
                    w_state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (l2_resp_valid_i) w_cnt_n = r_cnt + 1'b1;
                if (w_last) begin
                    w_cnt_n   = '0;
                    w_state_n = S_IDLE;
                end
            end
            S_DELIVER: begin
                if (!r_inv_pending) w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
        if (w_state_n == S_IDLE) w_kill_n = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_kill  <= 1'b0;
            r_paddr <= '0;
            r_way   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_kill  <= w_kill_n;
            if (w_accept) begin
                r_paddr <= req_paddr_i;
                r_way   <= req_way_i;
            end
        end
    end

    // Pending entry lives exactly one cycle: it is the response slot itself.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_inv_pending <= 1'b0;
            r_inv_paddr   <= '0;
        end else begin
            r_inv_pending <= w_inv_acc;
            if (w_inv_acc) r_inv_paddr <= l2_inv_paddr_i;
        end
    end

    assign l2_req_valid_o    = (r_state == S_SEND);
    assign l2_req_paddr_o    = r_paddr;
    assign l2_inv_ready_o    = !r_inv_pending;
    assign ifill_valid_o     = r_inv_pending || (r_state == S_DELIVER);
    assign ifill_inv_valid_o = r_inv_pending;
    assign ifill_inv_paddr_o = r_inv_paddr;
    assign ifill_data_o      = w_line;
    assign ifill_way_o       = r_way;
    assign busy_o            = (r_state != S_IDLE);
endmodule

// File: tb/tb_sargantana_icache_ifill_unit.sv
// Directed bench for the icache refill unit (default params, 2 beats per line).

module tb_sargantana_icache_ifill_unit;
    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic         req_valid_i;
    logic [39:0]  req_paddr_i;
    logic [1:0]   req_way_i;
    logic         req_kill_i;
    logic         l2_req_valid_o;
    logic         l2_req_ready_i;
    logic [39:0]  l2_req_paddr_o;
    logic         l2_resp_valid_i;
    logic [0:0]   l2_resp_beat_i;
    logic [127:0] l2_resp_data_i;
    logic         l2_inv_valid_i;
    logic [39:0]  l2_inv_paddr_i;
    logic         l2_inv_ready_o;
    logic         ifill_valid_o;
    logic         ifill_inv_valid_o;
    logic [39:0]  ifill_inv_paddr_o;
    logic [255:0] ifill_data_o;
    logic [1:0]   ifill_way_o;
    logic         busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] DA = {4{32'hAAAA_0001}};
    localparam logic [127:0] DB = {4{32'hBBBB_0002}};
    localparam logic [127:0] DC = {4{32'hCCCC_0003}};
    localparam logic [127:0] DD = {4{32'hDDDD_0004}};

    sargantana_icache_ifill_unit dut (
        .clk_i             (clk_i),
        .rstn_i            (rstn_i),
        .req_valid_i       (req_valid_i),
        .req_paddr_i       (req_paddr_i),
        .req_way_i         (req_way_i),
        .req_kill_i        (req_kill_i),
        .l2_req_valid_o    (l2_req_valid_o),
        .l2_req_ready_i    (l2_req_ready_i),
        .l2_req_paddr_o    (l2_req_paddr_o),
        .l2_resp_valid_i   (l2_resp_valid_i),
        .l2_resp_beat_i    (l2_resp_beat_i),
        .l2_resp_data_i    (l2_resp_data_i),
        .l2_inv_valid_i    (l2_inv_valid_i),
        .l2_inv_paddr_i    (l2_inv_paddr_i),
        .l2_inv_ready_o    (l2_inv_ready_o),
        .ifill_valid_o     (ifill_valid_o),
        .ifill_inv_valid_o (ifill_inv_valid_o),
        .ifill_inv_paddr_o (ifill_inv_paddr_o),
        .ifill_data_o      (ifill_data_o),
        .ifill_way_o       (ifill_way_o),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Request accepted into SEND, L2 ready on the next cycle: ends in WAIT.
    task automatic do_req(input logic [39:0] pa, input logic [1:0] way);
        req_valid_i = 1'b1; req_paddr_i = pa; req_way_i = way;
        tick();
        req_valid_i = 1'b0;
        l2_req_ready_i = 1'b1;
        tick();
        l2_req_ready_i = 1'b0;
    endtask

    task automatic set_beat(input logic v, input logic b, input logic [127:0] d);
        l2_resp_valid_i = v; l2_resp_beat_i = b; l2_resp_data_i = d;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        req_valid_i = 0; req_paddr_i = '0; req_way_i = '0; req_kill_i = 0;
        l2_req_ready_i = 0; l2_resp_valid_i = 0; l2_resp_beat_i = '0;
        l2_resp_data_i = '0; l2_inv_valid_i = 0; l2_inv_paddr_i = '0;
        #3;
        n_tests++;
        if ({l2_req_valid_o, ifill_valid_o, ifill_inv_valid_o, busy_o, l2_inv_ready_o} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b exp 00001",
                     {l2_req_valid_o, ifill_valid_o, ifill_inv_valid_o, busy_o, l2_inv_ready_o});
        end
        n_tests++;
        if (ifill_data_o !== '0 || ifill_way_o !== 2'd0 || l2_req_paddr_o !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got data %h way %0d paddr %h exp 0", ifill_data_o, ifill_way_o, l2_req_paddr_o);
        end
        tick(); tick();
        rstn_i = 1'b1;
        tick();
    endtask

    task automatic test_basic_fill();
        req_valid_i = 1'b1; req_paddr_i = 40'h80001000; req_way_i = 2'd2;
        tick();
        req_valid_i = 1'b0;
        n_tests++;
        if (l2_req_valid_o !== 1'b1 || l2_req_paddr_o !== 40'h80001000 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_send: got valid %b paddr %h busy %b exp 1 80001000 1", l2_req_valid_o, l2_req_paddr_o, busy_o);
        end
        l2_req_ready_i = 1'b1;
        tick();
        l2_req_ready_i = 1'b0;
        n_tests++;
        if (l2_req_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_req_drop: got %b exp 0", l2_req_valid_o);
        end
        set_beat(1, 0, DA); tick();
        n_tests++;
        if (ifill_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early: got ifill_valid %b exp 0", ifill_valid_o);
        end
        set_beat(1, 1, DB); tick();
        set_beat(0, 0, '0);
        // Kill during DELIVER must not cancel the fill.
        req_kill_i = 1'b1;
        n_tests++;
        if (ifill_valid_o !== 1'b1 || ifill_inv_valid_o !== 1'b0 || ifill_data_o !== {DB, DA} || ifill_way_o !== 2'd2) begin
            n_fail++;
            $display("FAIL basic_deliver: got v %b inv %b way %0d data %h exp 1 0 2 %h",
                     ifill_valid_o, ifill_inv_valid_o, ifill_way_o, ifill_data_o, {DB, DA});
        end
        tick();
        req_kill_i = 1'b0;
        n_tests++;
        if (ifill_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got valid %b busy %b exp 0 0", ifill_valid_o, busy_o);
        end
    endtask

    task automatic test_out_of_order();
        do_req(40'h80003000, 2'd1);
        set_beat(1, 1, DD); tick();
        set_beat(1, 0, DC); tick();
        set_beat(0, 0, '0);
        n_tests++;
        if (ifill_valid_o !== 1'b1 || ifill_data_o !== {DD, DC} || ifill_way_o !== 2'd1) begin
            n_fail++;
            $display("FAIL ooo_deliver: got v %b way %0d data %h exp 1 1 %h", ifill_valid_o, ifill_way_o, ifill_data_o, {DD, DC});
        end
        tick();
    endtask

    task automatic test_kill_wait();
        do_req(40'h80004000, 2'd3);
        set_beat(1, 0, DC); tick();
        set_beat(0, 0, '0); req_kill_i = 1'b1; tick();
        req_kill_i = 1'b0;
        n_tests++;
        if (busy_o !== 1'b1 || ifill_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_drain: got busy %b valid %b exp 1 0", busy_o, ifill_valid_o);
        end
        set_beat(1, 1, DD); tick();
        set_beat(0, 0, '0);
        n_tests++;
        if (busy_o !== 1'b0 || ifill_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_idle: got busy %b valid %b exp 0 0", busy_o, ifill_valid_o);
        end
        tick();
        n_tests++;
        if (ifill_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_nofill: got valid %b exp 0", ifill_valid_o);
        end
        do_req(40'h80005000, 2'd0);
        set_beat(1, 0, DB); tick();
        set_beat(1, 1, DA); tick();
        set_beat(0, 0, '0);
        n_tests++;
        if (ifill_valid_o !== 1'b1 || ifill_data_o !== {DA, DB} || ifill_way_o !== 2'd0) begin
            n_fail++;
            $display("FAIL kill_refill: got v %b way %0d data %h exp 1 0 %h", ifill_valid_o, ifill_way_o, ifill_data_o, {DA, DB});
        end
        tick();
    endtask

    task automatic test_inv_merge();
        do_req(40'h80006000, 2'd1);
        set_beat(1, 0, DA); tick();
        set_beat(1, 1, DB);
        l2_inv_valid_i = 1'b1; l2_inv_paddr_i = 40'h80002000;
        n_tests++;
        if (l2_inv_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL inv_ready: got %b exp 1", l2_inv_ready_o);
        end
        tick();
        set_beat(0, 0, '0); l2_inv_valid_i = 1'b0;
        n_tests++;
        if (ifill_valid_o !== 1'b1 || ifill_inv_valid_o !== 1'b1 || ifill_inv_paddr_o !== 40'h80002000 || l2_inv_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_first: got v %b inv %b pa %h rdy %b exp 1 1 80002000 0",
                     ifill_valid_o, ifill_inv_valid_o, ifill_inv_paddr_o, l2_inv_ready_o);
        end
        tick();
        n_tests++;
        if (ifill_valid_o !== 1'b1 || ifill_inv_valid_o !== 1'b0 || ifill_data_o !== {DB, DA} || ifill_way_o !== 2'd1) begin
            n_fail++;
            $display("FAIL inv_fill_after: got v %b inv %b way %0d data %h exp 1 0 1 %h",
                     ifill_valid_o, ifill_inv_valid_o, ifill_way_o, ifill_data_o, {DB, DA});
        end
        tick();
        n_tests++;
        if (ifill_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_fill_once: got v %b busy %b exp 0 0", ifill_valid_o, busy_o);
        end
    endtask

    task automatic test_back_to_back_inv();
        l2_inv_valid_i = 1'b1; l2_inv_paddr_i = 40'h000000A0;
        tick();
        n_tests++;
        if (l2_inv_ready_o !== 1'b0 || ifill_inv_valid_o !== 1'b1 || ifill_inv_paddr_o !== 40'h000000A0) begin
            n_fail++;
            $display("FAIL b2b_first: got rdy %b inv %b pa %h exp 0 1 a0", l2_inv_ready_o, ifill_inv_valid_o, ifill_inv_paddr_o);
        end
        l2_inv_paddr_i = 40'h000000C0;
        tick();
        n_tests++;
        if (l2_inv_ready_o !== 1'b1 || ifill_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: got rdy %b valid %b exp 1 0", l2_inv_ready_o, ifill_valid_o);
        end
        tick();
        l2_inv_valid_i = 1'b0;
        n_tests++;
        if (ifill_inv_valid_o !== 1'b1 || ifill_inv_paddr_o !== 40'h000000C0) begin
            n_fail++;
            $display("FAIL b2b_second: got inv %b pa %h exp 1 c0", ifill_inv_valid_o, ifill_inv_paddr_o);
        end
        tick();
        n_tests++;
        if (l2_inv_ready_o !== 1'b1 || ifill_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got rdy %b valid %b exp 1 0", l2_inv_ready_o, ifill_valid_o);
        end
    endtask

    task automatic test_kill_send();
        req_valid_i = 1'b1; req_paddr_i = 40'h80007000; req_way_i = 2'd2;
        tick();
        req_valid_i = 1'b0; req_kill_i = 1'b1;
        tick();
        req_kill_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (l2_req_valid_o !== 1'b1 || l2_req_paddr_o !== 40'h80007000) begin
                n_fail++;
                $display("FAIL send_hold[%0d]: got v %b pa %h exp 1 80007000", i, l2_req_valid_o, l2_req_paddr_o);
            end
            tick();
        end
        l2_req_ready_i = 1'b1;
        tick();
        l2_req_ready_i = 1'b0;
        n_tests++;
        if (l2_req_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL send_drain: got v %b busy %b exp 0 1", l2_req_valid_o, busy_o);
        end
        set_beat(1, 0, DC); tick();
        n_tests++;
        if (ifill_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL send_drain_mid: got v %b busy %b exp 0 1", ifill_valid_o, busy_o);
        end
        set_beat(1, 1, DD); tick();
        set_beat(0, 0, '0);
        n_tests++;
        if (ifill_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL send_drain_end: got v %b busy %b exp 0 0", ifill_valid_o, busy_o);
        end
    endtask

    task automatic test_kill_last_beat();
        do_req(40'h80008000, 2'd3);
        set_beat(1, 0, DA); tick();
        set_beat(1, 1, DB); req_kill_i = 1'b1; tick();
        set_beat(0, 0, '0); req_kill_i = 1'b0;
        n_tests++;
        if (ifill_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_last: got v %b busy %b exp 0 0", ifill_valid_o, busy_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_req(40'h80009000, 2'd1);
        set_beat(1, 0, DD); tick();
        set_beat(0, 0, '0);
        rstn_i = 1'b0;
        #1;
        n_tests++;
        if ({l2_req_valid_o, ifill_valid_o, ifill_inv_valid_o, busy_o, l2_inv_ready_o} !== 5'b00001 ||
            ifill_data_o !== '0 || ifill_way_o !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got ctl %b way %0d data %h exp 00001 0 0",
                     {l2_req_valid_o, ifill_valid_o, ifill_inv_valid_o, busy_o, l2_inv_ready_o}, ifill_way_o, ifill_data_o);
        end
        #1 rstn_i = 1'b1;
        tick();
        set_beat(1, 1, DC); tick();
        set_beat(0, 0, '0);
        n_tests++;
        if (ifill_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_idle: got v %b busy %b exp 0 0", ifill_valid_o, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_out_of_order();
        test_kill_wait();
        test_inv_merge();
        test_back_to_back_inv();
        test_kill_send();
        test_kill_last_beat();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
